// File: rtl/sc_matrix_scan.sv
// Row-scanned 8x8 LED matrix driver with a host-written shadow buffer.
// The shadow buffer is copied into the display buffer only at a frame boundary or while idle.
module sc_matrix_scan #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic       SC_MATRIX_SCAN_CLOCK_50,
  input  logic       SC_MATRIX_SCAN_RESET_InLow,
  input  logic       SC_MATRIX_SCAN_enable_InHigh,
  input  logic       SC_MATRIX_SCAN_wrvalid_InHigh,
  input  logic [2:0] SC_MATRIX_SCAN_wraddr_InBUS,
  input  logic [7:0] SC_MATRIX_SCAN_wrdata_InBUS,
  output logic       SC_MATRIX_SCAN_wrready_OutHigh,
  input  logic       SC_MATRIX_SCAN_swap_InHigh,
  output logic [7:0] SC_MATRIX_SCAN_data_OutBUS,
  output logic       SC_MATRIX_SCAN_select_OutLow,
  output logic [7:0] SC_MATRIX_SCAN_row_OutBUS,
  output logic       SC_MATRIX_SCAN_framedone_OutHigh,
  output logic       SC_MATRIX_SCAN_swappend_OutHigh
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned ROWS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  logic clk;
  logic rst_n;
  assign clk   = SC_MATRIX_SCAN_CLOCK_50;
  assign rst_n = SC_MATRIX_SCAN_RESET_InLow;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shadow_q [ROWS];
  logic [DATA_W-1:0]   shadow_d [ROWS];
  logic [DATA_W-1:0]   disp_q [ROWS];
  logic [DATA_W-1:0]   disp_d [ROWS];
  logic                pend_q, pend_d;
  logic                fd_q, fd_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   row_q, row_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wrready_q, wrready_d;
  logic                last_show;
  logic                frame_end;
  logic                copy;

  // Next-state, buffer update and registered-output decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    fd_d      = 1'b0;
    last_show = (state_q == ST_SHOW) && (cnt_q == CNT_W'(DWELL - 1));
    frame_end = last_show && (idx_q == IDX_W'(ROWS - 1));

    if (!SC_MATRIX_SCAN_enable_InHigh) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (last_show) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            fd_d    = frame_end;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A swap request on the frame-end edge itself is honoured immediately
    copy = ((state_q == ST_IDLE) && pend_q) ||
           (SC_MATRIX_SCAN_enable_InHigh && frame_end &&
            (pend_q || SC_MATRIX_SCAN_swap_InHigh));
    if (copy) begin
      disp_d = shadow_q;
    end
    if (SC_MATRIX_SCAN_wrvalid_InHigh && !pend_q) begin
      shadow_d[SC_MATRIX_SCAN_wraddr_InBUS] = SC_MATRIX_SCAN_wrdata_InBUS;
    end
    if (copy) begin
      pend_d = 1'b0;
    end else if (SC_MATRIX_SCAN_swap_InHigh) begin
      pend_d = 1'b1;
    end

    sel_d     = (state_d != ST_SHOW);
    row_d     = (state_d == ST_SHOW) ? ~(DATA_W'(1) << idx_d) : {DATA_W{1'b1}};
    data_d    = (state_d == ST_SHOW) ? disp_d[idx_d] : '0;
    wrready_d = !pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      fd_q      <= 1'b0;
      sel_q     <= 1'b1;
      row_q     <= {DATA_W{1'b1}};
      data_q    <= '0;
      wrready_q <= 1'b1;
      for (int i = 0; i < ROWS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      fd_q      <= fd_d;
      sel_q     <= sel_d;
      row_q     <= row_d;
      data_q    <= data_d;
      wrready_q <= wrready_d;
      for (int i = 0; i < ROWS; i++) begin
        shadow_q[i] <= shadow_d[i];
        disp_q[i]   <= disp_d[i];
      end
    end
  end

  assign SC_MATRIX_SCAN_wrready_OutHigh   = wrready_q;
  assign SC_MATRIX_SCAN_data_OutBUS       = data_q;
  assign SC_MATRIX_SCAN_select_OutLow     = sel_q;
  assign SC_MATRIX_SCAN_row_OutBUS        = row_q;
  assign SC_MATRIX_SCAN_framedone_OutHigh = fd_q;
  assign SC_MATRIX_SCAN_swappend_OutHigh  = pend_q;

endmodule

// File: tb/tb_sc_matrix_scan.sv
// Directed bench for sc_matrix_scan (DWELL=4, BLANK=2) with a time-position scan model.
module tb_sc_matrix_scan;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int P  = BL + DW;
  localparam int FR = 8 * P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       wv;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       sw;
  logic       wrready;
  logic [7:0] data;
  logic       sel;
  logic [7:0] row;
  logic       fd;
  logic       pend;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  sc_matrix_scan #(.DWELL(DW), .BLANK(BL)) dut (
    .SC_MATRIX_SCAN_CLOCK_50         (clk),
    .SC_MATRIX_SCAN_RESET_InLow      (rst_n),
    .SC_MATRIX_SCAN_enable_InHigh    (en),
    .SC_MATRIX_SCAN_wrvalid_InHigh   (wv),
    .SC_MATRIX_SCAN_wraddr_InBUS     (wa),
    .SC_MATRIX_SCAN_wrdata_InBUS     (wd),
    .SC_MATRIX_SCAN_wrready_OutHigh  (wrready),
    .SC_MATRIX_SCAN_swap_InHigh      (sw),
    .SC_MATRIX_SCAN_data_OutBUS      (data),
    .SC_MATRIX_SCAN_select_OutLow    (sel),
    .SC_MATRIX_SCAN_row_OutBUS       (row),
    .SC_MATRIX_SCAN_framedone_OutHigh(fd),
    .SC_MATRIX_SCAN_swappend_OutHigh (pend)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Model: scan position is just "cycles since enable" modulo one frame
  bit         m_act;
  int         m_t;
  logic [7:0] m_sh [8];
  logic [7:0] m_dp [8];
  bit         m_pend;
  bit         m_fd;

  always @(posedge clk or negedge rst_n) begin
    bit cp;
    bit ex7;
    if (!rst_n) begin
      m_act = 1'b0; m_t = 0; m_pend = 1'b0; m_fd = 1'b0;
      for (int i = 0; i < 8; i++) begin m_sh[i] = 8'h00; m_dp[i] = 8'h00; end
    end else begin
      ex7  = m_act && ((m_t % FR) == FR - 1);
      cp   = (!m_act && m_pend) || (m_act && en && ex7 && (m_pend || sw));
      m_fd = m_act && en && ex7;
      if (cp) for (int i = 0; i < 8; i++) m_dp[i] = m_sh[i];
      if (wv && !m_pend) m_sh[wa] = wd;
      if (cp) m_pend = 1'b0;
      else if (sw) m_pend = 1'b1;
      if (!en) begin m_act = 1'b0; m_t = 0; end
      else if (!m_act) begin m_act = 1'b1; m_t = 0; end
      else m_t = (m_t + 1) % FR;
    end
  end

  always @(negedge clk) begin
    logic       e_sel;
    logic [7:0] e_row;
    logic [7:0] e_data;
    int         r;
    if (cmp_on) begin
      e_sel = 1'b1; e_row = 8'hFF; e_data = 8'h00;
      if (m_act && (m_t % P) >= BL) begin
        r      = (m_t / P) % 8;
        e_sel  = 1'b0;
        e_row  = 8'hFF ^ (8'h01 << r);
        e_data = m_dp[r];
      end
      chk("m_select", {7'd0, sel}, {7'd0, e_sel});
      chk("m_row", row, e_row);
      chk("m_data", data, e_data);
      chk("m_framedone", {7'd0, fd}, {7'd0, m_fd});
      chk("m_swappend", {7'd0, pend}, {7'd0, m_pend});
      chk("m_wrready", {7'd0, wrready}, {7'd0, !m_pend});
    end
  end

  initial begin
    int fd_cnt;
    fd_cnt = 0;
    rst_n = 1'b0; en = 1'b0; wv = 1'b0; wa = 3'd0; wd = 8'h00; sw = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_select", {7'd0, sel}, 8'h01);
    chk("rst_row", row, 8'hFF);
    chk("rst_data", data, 8'h00);
    chk("rst_framedone", {7'd0, fd}, 8'h00);
    chk("rst_swappend", {7'd0, pend}, 8'h00);
    chk("rst_wrready", {7'd0, wrready}, 8'h01);
    cmp_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wv = 1'b1; wa = 3'(i); wd = 8'(8'h81 + i);
    end
    @(negedge clk);
    wv = 1'b0; en = 1'b1;

    for (int n = 1; n <= 170; n++) begin
      @(negedge clk);
      if (n <= 49 && fd) fd_cnt++;
      if (n == 1 || n == 2) begin
        chk("blank_select", {7'd0, sel}, 8'h01);
        chk("blank_row", row, 8'hFF);
      end
      if (n == 3) begin
        chk("row0_select", {7'd0, sel}, 8'h00);
        chk("row0_row", row, 8'hFE);
        chk("row0_data", data, 8'h00);
        sw = 1'b1;
      end
      if (n == 4) begin
        sw = 1'b0;
        chk("pend_set", {7'd0, pend}, 8'h01);
        chk("pend_wrready", {7'd0, wrready}, 8'h00);
      end
      if (n == 5) begin wv = 1'b1; wa = 3'd3; wd = 8'hAA; end
      if (n == 6) begin
        wv = 1'b0;
        chk("pend_wrready2", {7'd0, wrready}, 8'h00);
      end
      if (n == 7) chk("blank2_row", row, 8'hFF);
      if (n == 9) chk("row1_row", row, 8'hFD);
      if (n == 48) chk("no_early_fd", {7'd0, fd}, 8'h00);
      if (n == 49) begin
        chk("framedone", {7'd0, fd}, 8'h01);
        chk("fd_once", 8'(fd_cnt), 8'h01);
        chk("swap_cleared", {7'd0, pend}, 8'h00);
      end
      if (n == 51) chk("f2_row0_data", data, 8'h81);
      if (n >= 60 && n <= 67) begin
        wv = (n != 63); wa = 3'(n - 60); wd = 8'(8'h40 + (n - 60));
      end
      if (n == 68) wv = 1'b0;
      if (n == 93) begin
        chk("f2_row7_row", row, 8'h7F);
        chk("f2_row7_data", data, 8'h88);
      end
      if (n == 96) sw = 1'b1;
      if (n == 97) begin
        sw = 1'b0;
        chk("edge_swap_pend", {7'd0, pend}, 8'h00);
        chk("edge_swap_fd", {7'd0, fd}, 8'h01);
      end
      if (n == 99) chk("f3_row0_data", data, 8'h40);
      if (n == 117) begin
        chk("f3_row3_row", row, 8'hF7);
        chk("f3_row3_data", data, 8'h84);
      end
      if (n == 130) en = 1'b0;
      if (n == 131) begin
        chk("dis_select", {7'd0, sel}, 8'h01);
        chk("dis_row", row, 8'hFF);
        chk("dis_fd", {7'd0, fd}, 8'h00);
      end
      if (n == 134) en = 1'b1;
      if (n == 137) begin
        chk("reen_row", row, 8'hFE);
        chk("reen_data", data, 8'h40);
      end
      if (n == 156) begin
        chk("pre_rst_row", row, 8'hF7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_select", {7'd0, sel}, 8'h01);
        chk("async_row", row, 8'hFF);
        chk("async_data", data, 8'h00);
        chk("async_wrready", {7'd0, wrready}, 8'h01);
      end
      if (n == 158) rst_n = 1'b1;
      if (n == 161) begin
        chk("post_rst_row", row, 8'hFE);
        chk("post_rst_data", data, 8'h00);
      end
    end
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
